rv_imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode pipeline stage for the RV core family. It decodes the immediate of any RV32I/RV64I base instruction, plus the Zicsr `zimm` field, and sign-extends it to XLEN. It also reports the instruction format and an illegal-opcode flag. The stage sits between fetch and the register-read/execute stage behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or reorders instructions.

---
 rtl/rv_pkg.sv | 77 +++++++
 rtl/rv_skid_buf.sv | 82 ++++++++
 rtl/rv_imm_decode_stage.sv | 71 +++++++
 tb/tb_rv_imm_decode_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV decode definitions: opcode constants, immediate format codes and
// the immediate extraction function used by the decode stage.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e    fmt;
        logic        illegal;
        logic [63:0] imm;
    } imm_dec_t;

    // Immediate is built at 64 bits; a 32-bit datapath keeps the low half,
    // which is the same value sign-extended to 32. SYSTEM is always decoded
    // here; the Zicsr gate is applied by the caller.
    function automatic imm_dec_t rv_imm_extract(input logic [31:0] ir,
                                                input logic        xlen_is64);
        imm_dec_t r;
        r.fmt     = FMT_NONE;
        r.illegal = 1'b0;
        r.imm     = '0;
        if (ir[1:0] != 2'b11) begin
            r.illegal = 1'b1;
        end else begin
            case (ir[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_JALR: r.fmt = FMT_I;
                OPC_OP_IMM_32: begin
                    if (xlen_is64) r.fmt = FMT_I;
                    else           r.illegal = 1'b1;
                end
                OPC_STORE:           r.fmt = FMT_S;
                OPC_BRANCH:          r.fmt = FMT_B;
                OPC_LUI, OPC_AUIPC:  r.fmt = FMT_U;
                OPC_JAL:             r.fmt = FMT_J;
                OPC_OP:              r.fmt = FMT_NONE;
                OPC_OP_32: begin
                    if (!xlen_is64) r.illegal = 1'b1;
                end
                OPC_SYSTEM:          r.fmt = ir[14] ? FMT_Z : FMT_I;
                default:             r.illegal = 1'b1;
            endcase
        end
        case (r.fmt)
            FMT_I:   r.imm = {{52{ir[31]}}, ir[31:20]};
            FMT_S:   r.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   r.imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   r.imm = {{32{ir[31]}}, ir[31:12], 12'b0};
            FMT_J:   r.imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            FMT_Z:   r.imm = {59'b0, ir[19:15]};
            default: r.imm = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main register drives the
// output, the skid register absorbs one extra beat while downstream stalls.
module rv_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    // Handshake: a beat transfers on a rising edge where valid && ready are
    // both high; a valid source holds its payload until that edge.
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         handoff;

    assign accept  = in_valid_i && in_ready_q;
    assign handoff = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            // After any handoff shuffle, a new beat lands in the first free slot.
            if (accept) begin
                if (!main_valid_d) begin
                    main_data_d  = in_data_i;
                    main_valid_d = 1'b1;
                end else begin
                    skid_data_d  = in_data_i;
                    skid_valid_d = 1'b1;
                end
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/rv_imm_decode_stage.sv
// Registered immediate-decode stage: decodes on the input side, then holds
// {ir, pc, imm, fmt, illegal} in a 2-entry skid buffer toward execute.
module rv_imm_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ZICSR_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    localparam int PW = $bits(entry_t);

    entry_t in_entry;
    entry_t out_entry;

    always_comb begin
        imm_dec_t dec;
        dec = rv_imm_extract(in_ir, XLEN == 64);
        if (ZICSR_EN == 0 && in_ir[6:0] == OPC_SYSTEM) begin
            dec.fmt     = FMT_NONE;
            dec.illegal = 1'b1;
            dec.imm     = '0;
        end
        in_entry.ir      = in_ir;
        in_entry.pc      = in_pc;
        in_entry.imm     = dec.imm[XLEN-1:0];
        in_entry.fmt     = dec.fmt;
        in_entry.illegal = dec.illegal;
    end

    rv_skid_buf #(.W(PW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_entry)
    );

    assign out_ir      = out_entry.ir;
    assign out_pc      = out_entry.pc;
    assign out_imm     = out_entry.imm;
    assign out_fmt     = out_entry.fmt;
    assign out_illegal = out_entry.illegal;

endmodule

// File: tb/tb_rv_imm_decode_stage.sv
// Bench for rv_imm_decode_stage: a 32-bit/Zicsr instance and a 64-bit/no-Zicsr
// instance share stimulus; directed table, random scoreboard, corner sequences.
module tb_rv_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_ir = '0;
    logic [63:0] in_pc = '0;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_ir32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [31:0] out_ir64;
    logic [63:0] out_pc64, out_imm64;
    logic [2:0]  out_fmt64;

    rv_imm_decode_stage #(.XLEN(32), .ZICSR_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_ir(in_ir), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_ir(out_ir32), .out_pc(out_pc32),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_ill32)
    );

    rv_imm_decode_stage #(.XLEN(64), .ZICSR_EN(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready), .out_ir(out_ir64), .out_pc(out_pc64),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_ill64)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode from the instruction-set rules, using signed arithmetic.
    function automatic void model(input logic [31:0] ir, input bit is64, input bit zicsr,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
        longint v;
        v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ir[1:0] != 2'b11) ill = 1'b1;
        else begin
            case (ir[6:0])
                7'h03, 7'h13, 7'h0F, 7'h67: fmt = 3'd1;
                7'h1B: if (is64) fmt = 3'd1; else ill = 1'b1;
                7'h23: fmt = 3'd2;
                7'h63: fmt = 3'd3;
                7'h37, 7'h17: fmt = 3'd4;
                7'h6F: fmt = 3'd5;
                7'h33: fmt = 3'd0;
                7'h3B: if (!is64) ill = 1'b1;
                7'h73: if (!zicsr) ill = 1'b1; else fmt = ir[14] ? 3'd6 : 3'd1;
                default: ill = 1'b1;
            endcase
        end
        case (fmt)
            3'd1: begin v = longint'(ir[31:20]); if (ir[31]) v -= 64'sd4096; end
            3'd2: begin
                v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
                if (ir[31]) v -= 64'sd4096;
            end
            3'd3: begin
                v = longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2 + (ir[7] ? 64'sd2048 : 64'sd0);
                if (ir[31]) v -= 64'sd4096;
            end
            3'd4: begin
                v = longint'(ir[31:12]) * 4096;
                if (ir[31]) v -= 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(ir[30:21]) * 2 + (ir[20] ? 64'sd2048 : 64'sd0) + longint'(ir[19:12]) * 4096;
                if (ir[31]) v -= 64'sd1048576;
            end
            3'd6: v = longint'(ir[19:15]);
            default: v = 0;
        endcase
        imm = is64 ? 64'(v) : {32'h0, v[31:0]};
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 13))
                0: r[6:0] = 7'h03;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h0F;
                3: r[6:0] = 7'h67;  4: r[6:0] = 7'h1B;  5: r[6:0] = 7'h23;
                6: r[6:0] = 7'h63;  7: r[6:0] = 7'h37;  8: r[6:0] = 7'h17;
                9: r[6:0] = 7'h6F;  10: r[6:0] = 7'h33; 11: r[6:0] = 7'h3B;
                12: r[6:0] = 7'h73; default: r[6:0] = 7'h7F;
            endcase
        end
        return r;
    endfunction

    // Scoreboard: accepted-but-not-delivered instructions, in order.
    logic [31:0] exp_q[$];
    logic [63:0] pc_q[$];
    bit acc_last = 1'b0;

    task automatic check_payload(input string tag, input logic [31:0] ir, input logic [63:0] pc);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        model(ir, 1'b0, 1'b1, e_imm, e_fmt, e_ill);
        chk({tag, "_ir32"}, 64'(out_ir32), 64'(ir));
        chk({tag, "_pc32"}, 64'(out_pc32), 64'(pc[31:0]));
        chk({tag, "_imm32"}, 64'(out_imm32), e_imm);
        chk({tag, "_fmt32"}, 64'(out_fmt32), 64'(e_fmt));
        chk({tag, "_ill32"}, 64'(out_ill32), 64'(e_ill));
        model(ir, 1'b1, 1'b0, e_imm, e_fmt, e_ill);
        chk({tag, "_ir64"}, 64'(out_ir64), 64'(ir));
        chk({tag, "_pc64"}, out_pc64, pc);
        chk({tag, "_imm64"}, out_imm64, e_imm);
        chk({tag, "_fmt64"}, 64'(out_fmt64), 64'(e_fmt));
        chk({tag, "_ill64"}, 64'(out_ill64), 64'(e_ill));
    endtask

    task automatic sb_check();
        chk("sb_valid32", 64'(out_valid32), 64'(exp_q.size() != 0));
        chk("sb_valid64", 64'(out_valid64), 64'(exp_q.size() != 0));
        chk("sb_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
        chk("sb_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
        if (exp_q.size() != 0) check_payload("sb", exp_q[0], pc_q[0]);
    endtask

    // Predicts the coming edge from the current inputs and model occupancy.
    task automatic sb_commit();
        int  n;
        bit  pop, push;
        n    = exp_q.size();
        pop  = (n != 0) && out_ready;
        push = in_valid && (n < 2);
        if (pop) begin
            void'(exp_q.pop_front());
            void'(pc_q.pop_front());
        end
        if (push) begin
            exp_q.push_back(in_ir);
            pc_q.push_back(in_pc);
        end
        acc_last = push;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_ready32"}, 64'(in_ready32), 64'd1);
        chk({tag, "_ir32"}, 64'(out_ir32), 64'd0);
        chk({tag, "_pc32"}, 64'(out_pc32), 64'd0);
        chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
        chk({tag, "_fmt32"}, 64'(out_fmt32), 64'd0);
        chk({tag, "_ill32"}, 64'(out_ill32), 64'd0);
        chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_ready64"}, 64'(in_ready64), 64'd1);
        chk({tag, "_imm64"}, out_imm64, 64'd0);
        chk({tag, "_pc64"}, out_pc64, 64'd0);
        chk({tag, "_fmt64"}, 64'(out_fmt64), 64'd0);
    endtask

    typedef struct {
        logic [31:0] ir;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];
    logic [31:0] bp[4];
    bit  will;
    int  idx, got, rdy_pct;

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
        vecs[3]  = '{32'h3400D073, 32'h00000001, 3'd6, 1'b0, 64'h0, 3'd0, 1'b1};
        vecs[4]  = '{32'h00000000, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        vecs[5]  = '{32'h0010009B, 32'h0, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0};
        vecs[6]  = '{32'h002081B3, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        vecs[7]  = '{32'h002081BB, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0};
        vecs[8]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0};
        vecs[9]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h8, 3'd5, 1'b0};
        vecs[10] = '{32'h00000001, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        vecs[11] = '{32'h00001017, 32'h00001000, 3'd4, 1'b0, 64'h1000, 3'd4, 1'b0};
        vecs[12] = '{32'h00000073, 32'h0, 3'd1, 1'b0, 64'h0, 3'd0, 1'b1};
        vecs[13] = '{32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0};
        vecs[14] = '{32'h0000007F, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        bp[0] = 32'h00100093; bp[1] = 32'h00200093; bp[2] = 32'h00300093; bp[3] = 32'h00400093;

        // Power-on reset
        #12;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, streamed back to back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tbl%0d_valid", i - 1), 64'(out_valid32), 64'd1);
                chk($sformatf("tbl%0d_ready", i - 1), 64'(in_ready32), 64'd1);
                chk($sformatf("tbl%0d_ir", i - 1), 64'(out_ir32), 64'(vecs[i-1].ir));
                chk($sformatf("tbl%0d_pc32", i - 1), 64'(out_pc32), 64'((i - 1) * 4));
                chk($sformatf("tbl%0d_imm32", i - 1), 64'(out_imm32), 64'(vecs[i-1].imm32));
                chk($sformatf("tbl%0d_fmt32", i - 1), 64'(out_fmt32), 64'(vecs[i-1].fmt32));
                chk($sformatf("tbl%0d_ill32", i - 1), 64'(out_ill32), 64'(vecs[i-1].ill32));
                chk($sformatf("tbl%0d_pc64", i - 1), out_pc64, 64'hA000_0000_0000_0000 + 64'((i - 1) * 4));
                chk($sformatf("tbl%0d_imm64", i - 1), out_imm64, vecs[i-1].imm64);
                chk($sformatf("tbl%0d_fmt64", i - 1), 64'(out_fmt64), 64'(vecs[i-1].fmt64));
                chk($sformatf("tbl%0d_ill64", i - 1), 64'(out_ill64), 64'(vecs[i-1].ill64));
            end
            if (i < NV) begin
                in_valid = 1'b1;
                in_ir    = vecs[i].ir;
                in_pc    = 64'hA000_0000_0000_0000 + 64'(i * 4);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Random traffic against the scoreboard
        rdy_pct = 100;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            sb_check();
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: rdy_pct = 10;
                    1: rdy_pct = 50;
                    2: rdy_pct = 90;
                    default: rdy_pct = 100;
                endcase
            end
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ir    = rand_ir();
                in_pc    = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            sb_commit();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            sb_check();
            sb_commit();
        end
        @(negedge clk);
        sb_check();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressure: A..D offered while out_ready is low for 4 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = bp[0];
        idx       = 0;
        for (int c = 0; c < 4; c++) begin
            will = in_valid && in_ready32;
            @(negedge clk);
            if (will) begin
                idx++;
                if (idx < 4) in_ir = bp[idx]; else in_valid = 1'b0;
            end
            if (c >= 1) chk("bp_hold_ir", 64'(out_ir32), 64'(bp[0]));
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready32), 64'd0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            will = in_valid && in_ready32;
            if (out_valid32) begin
                chk($sformatf("bp_order%0d", got), 64'(out_ir32), 64'(bp[got]));
                got++;
            end
            @(negedge clk);
            if (will) begin
                idx++;
                if (idx < 4) in_ir = bp[idx]; else in_valid = 1'b0;
            end
        end
        chk("bp_count", 64'(got), 64'd4);
        chk("bp_no_dup", 64'(out_valid32), 64'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = 32'h00500093;
        @(negedge clk);
        in_ir = 32'h00600093;
        @(negedge clk);
        chk("fl_full_valid", 64'(out_valid32), 64'd1);
        chk("fl_full_ready", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        in_ir = 32'h00700093;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid32", 64'(out_valid32), 64'd0);
        chk("fl_valid64", 64'(out_valid64), 64'd0);
        chk("fl_ready32", 64'(in_ready32), 64'd1);
        chk("fl_ready64", 64'(in_ready64), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_stay_empty", 64'(out_valid32), 64'd0);

        // Flush discarding a same-cycle accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = 32'h00800093;
        @(negedge clk);
        flush = 1'b1;
        in_ir = 32'h00900093;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flb_valid", 64'(out_valid32), 64'd0);
        chk("flb_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("flb_no_leak", 64'(out_valid32), 64'd0);
        end

        // Reset pulsed mid-stream, then accept on the first edge after release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ir     = 32'h00A00093;
        @(negedge clk);
        in_ir = 32'h00B00093;
        @(negedge clk);
        chk("rst_full_valid", 64'(out_valid32), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        in_valid = 1'b0;
        @(negedge clk);
        check_reset("rst_hold");
        in_valid  = 1'b1;
        in_ir     = 32'h00C00093;
        in_pc     = 64'h0000_0000_0000_1234;
        out_ready = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rel_valid", 64'(out_valid32), 64'd1);
        chk("rel_ir", 64'(out_ir32), 64'h00C00093);
        chk("rel_imm32", 64'(out_imm32), 64'd12);
        chk("rel_imm64", out_imm64, 64'd12);
        @(negedge clk);
        chk("rel_drained", 64'(out_valid32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
